// File: rtl/lsu_mem_master.sv
// -----------------------------------------------------------------------------
// lsu_mem_master
//   Load/store initiator between the RV32 core memory stage and
//   memory_controller_module. Takes one request at a time, issues a single
//   start pulse to the controller, waits for op_r, sign/zero-extends byte and
//   half loads, and returns a one-cycle response with an error flag.
//
// Optional build macro: LSU_ALIGN_CHECK_EN
//   defined   -> misaligned word/half requests get an immediate error response
//   undefined -> misaligned requests are issued unchanged
//
// Parameters
//   ADDR_W          controller address width
//   TIMEOUT_CYCLES  WAIT cycles before an access is abandoned (>= 6)
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   i_req_*, o_req_ready core request channel (accept = valid & ready)
//   o_resp_*             one-cycle response pulse, rdata and error flag
//   o_mem_*              controller enable/addr/we/data_in/instr_mode
//   i_mem_rdata/op_r     controller data_out and completion strobe
// -----------------------------------------------------------------------------
module lsu_mem_master #(
    parameter int ADDR_W         = 24,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_resp_valid,
    output logic [31:0]       o_resp_rdata,
    output logic              o_resp_err,
    output logic              o_mem_enable,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [31:0]       o_mem_wdata,
    output logic [1:0]        o_mem_mode,
    input  logic [31:0]       i_mem_rdata,
    input  logic              i_mem_op_r
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic [TW-1:0]     r_timer;

    logic              w_accept;
    logic              w_bad_req;
    logic              w_misalign;
    logic              w_timeout;
    logic [31:0]       w_ext;

`ifdef LSU_ALIGN_CHECK_EN
    assign w_misalign = ((i_req_size == 2'b00) && (i_req_addr[1:0] != 2'b00)) ||
                        ((i_req_size == 2'b10) && i_req_addr[0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_accept  = i_req_valid && (r_state == S_IDLE);
    // Rejected requests skip the controller entirely.
    assign w_bad_req = (i_req_size == 2'b11) || w_misalign;
    // The timer stops at the compare value, so it can never wrap.
    assign w_timeout = (r_timer == TIMER_LAST);

    // The controller zero-fills narrow reads; extension happens here.
    always_comb begin
        case (r_size)
            2'b01:   w_ext = {{24{~r_unsigned & i_mem_rdata[7]}},  i_mem_rdata[7:0]};
            2'b10:   w_ext = {{16{~r_unsigned & i_mem_rdata[15]}}, i_mem_rdata[15:0]};
            default: w_ext = i_mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred for w_next.
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_bad_req ? S_RESP : S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (i_mem_op_r || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_timer    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we       <= i_req_we;
                        r_size     <= i_req_size;
                        r_unsigned <= i_req_unsigned;
                        r_addr     <= i_req_addr;
                        r_wdata    <= i_req_wdata;
                        r_rdata    <= '0;
                        r_err      <= w_bad_req;
                    end
                end
                S_ISSUE: r_timer <= '0;
                S_WAIT: begin
                    if (i_mem_op_r) begin
                        if (!r_we) r_rdata <= w_ext;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status and strobes decode straight from the state, so an asynchronous
    // reset drops them without waiting for a clock edge.
    assign o_req_ready  = (r_state == S_IDLE);
    assign o_resp_valid = (r_state == S_RESP);
    assign o_resp_err   = (r_state == S_RESP) && r_err;
    assign o_resp_rdata = (r_state == S_RESP) ? r_rdata : 32'h0;
    assign o_mem_enable = (r_state == S_ISSUE);

    // Only an accept in IDLE can change these, so they are stable from
    // ISSUE through WAIT.
    assign o_mem_addr   = r_addr;
    assign o_mem_we     = r_we;
    assign o_mem_wdata  = r_wdata;
    assign o_mem_mode   = r_size;

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;

  localparam int ADDR_W = 24;
  localparam int TO     = 16;
`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_enable;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [1:0]        mem_mode;
  logic [31:0]       mem_rdata;
  logic              mem_op_r;
  logic              ctl_op_r;
  logic              inj_op_r = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign mem_op_r = ctl_op_r | inj_op_r;

  lsu_mem_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_we       (req_we),
    .i_req_size     (req_size),
    .i_req_unsigned (req_unsigned),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_resp_valid   (resp_valid),
    .o_resp_rdata   (resp_rdata),
    .o_resp_err     (resp_err),
    .o_mem_enable   (mem_enable),
    .o_mem_addr     (mem_addr),
    .o_mem_we       (mem_we),
    .o_mem_wdata    (mem_wdata),
    .o_mem_mode     (mem_mode),
    .i_mem_rdata    (mem_rdata),
    .i_mem_op_r     (mem_op_r)
  );

  // ---------------- controller model: op_r in the 5th WAIT cycle ----------
  logic [7:0]        ctl_mem [256];
  bit                ctl_loaded = 1'b0;
  bit                ctl_en = 1'b1;
  int                ctl_cnt = 0;
  logic [ADDR_W-1:0] c_addr;
  logic              c_we;
  logic [1:0]        c_mode;
  logic [31:0]       c_wdata;

  always @(negedge clk) begin
    if (!ctl_loaded) begin
      for (int i = 0; i < 256; i++) ctl_mem[i] = (i >= 16 && i <= 19) ? 8'hEE : 8'h00;
      mem_rdata  = '0;
      ctl_loaded = 1'b1;
    end
    ctl_op_r = 1'b0;
    if (ctl_cnt > 0) begin
      ctl_cnt--;
      if (ctl_cnt == 0) begin
        int n;
        n = (c_mode == 2'b01) ? 1 : (c_mode == 2'b10) ? 2 : 4;
        mem_rdata = '0;
        for (int i = 0; i < n; i++) begin
          if (c_we) ctl_mem[(int'(c_addr) + i) % 256] = c_wdata[8*i +: 8];
          else      mem_rdata[8*i +: 8] = ctl_mem[(int'(c_addr) + i) % 256];
        end
        ctl_op_r = 1'b1;
      end
    end
    if (mem_enable) begin
      ctl_cnt = ctl_en ? 5 : 0;
      c_addr  = mem_addr;
      c_we    = mem_we;
      c_mode  = mem_mode;
      c_wdata = mem_wdata;
    end
  end

  // ---------------- reference model --------------------------------------
  logic [7:0] ref_mem [256];

  task automatic model(input bit we, input logic [1:0] size, input bit uns,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output bit err, output int lat, output int en);
    int     n;
    int     a;
    longint v;
    a = int'(addr);
    rdata = '0;
    if (size == 2'b11 || (ALIGN && ((size == 2'b00 && a % 4 != 0) || (size == 2'b10 && a % 2 != 0)))) begin
      err = 1'b1; lat = 1; en = 0;
    end else begin
      err = 1'b0; lat = 7; en = 1;
      n = (size == 2'b01) ? 1 : (size == 2'b10) ? 2 : 4;
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[(a + i) % 256] = wdata[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[(a + i) % 256]) << (8 * i);
        if (!uns && n < 4 && v >= (64'sd1 <<< (8 * n - 1))) v -= (64'sd1 <<< (8 * n));
        rdata = v[31:0];
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic run_access(input string name, input bit we, input logic [1:0] size, input bit uns,
                            input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input bit exp_err, input int exp_lat, input int exp_en);
    int          lat = 0;
    int          en  = 0;
    logic [31:0] rd  = 'x;
    logic        er  = 1'bx;
    check($sformatf("%s.ready", name), 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (mem_enable) en++;
      if (resp_valid) begin
        lat = c; rd = resp_rdata; er = resp_err;
        break;
      end
    end
    check($sformatf("%s.lat", name), 32'(lat), 32'(exp_lat));
    check($sformatf("%s.rdata", name), rd, exp_rdata);
    check($sformatf("%s.err", name), 32'(er), 32'(exp_err));
    check($sformatf("%s.en", name), 32'(en), 32'(exp_en));
    @(negedge clk);
    check($sformatf("%s.pulse", name), {31'd0, resp_valid, 31'd0, req_ready} === 64'd1 ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check($sformatf("%s.ready", name), 32'(req_ready), 32'd1);
    check($sformatf("%s.rv", name), 32'(resp_valid), 32'd0);
    check($sformatf("%s.rerr", name), 32'(resp_err), 32'd0);
    check($sformatf("%s.rdata", name), resp_rdata, 32'd0);
    check($sformatf("%s.en", name), 32'(mem_enable), 32'd0);
    check($sformatf("%s.addr", name), 32'(mem_addr), 32'd0);
    check($sformatf("%s.we", name), 32'(mem_we), 32'd0);
    check($sformatf("%s.wdata", name), mem_wdata, 32'd0);
    check($sformatf("%s.mode", name), 32'(mem_mode), 32'd0);
  endtask

  typedef struct {
    bit                we;
    logic [1:0]        size;
    bit                uns;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    bit                err;
    int                lat;
    int                en;
  } vec_t;

  initial begin
    vec_t        vt[$];
    logic [31:0] e_rd;
    bit          e_err;
    int          e_lat, e_en, cnt;
    logic [3:0]  pat;

    for (int i = 0; i < 256; i++) ref_mem[i] = (i >= 16 && i <= 19) ? 8'hEE : 8'h00;

    vt.push_back('{0, 2'b01, 0, 16, 0, 32'hFFFFFFEE, 0, 7, 1});
    vt.push_back('{0, 2'b01, 1, 16, 0, 32'h000000EE, 0, 7, 1});
    vt.push_back('{0, 2'b10, 0, 16, 0, 32'hFFFFEEEE, 0, 7, 1});
    vt.push_back('{0, 2'b10, 1, 16, 0, 32'h0000EEEE, 0, 7, 1});
    vt.push_back('{0, 2'b00, 0, 16, 0, 32'hEEEEEEEE, 0, 7, 1});
    vt.push_back('{1, 2'b00, 0, 8, 32'h12345678, 32'h0, 0, 7, 1});
    vt.push_back('{0, 2'b00, 0, 8, 0, 32'h12345678, 0, 7, 1});
    vt.push_back('{0, 2'b11, 0, 0, 0, 32'h0, 1, 1, 0});
    vt.push_back('{1, 2'b11, 0, 4, 32'hFFFF, 32'h0, 1, 1, 0});
    vt.push_back('{0, 2'b00, 0, 2, 0, 32'h0, ALIGN, ALIGN ? 1 : 7, ALIGN ? 0 : 1});
    vt.push_back('{0, 2'b10, 0, 17, 0, ALIGN ? 32'h0 : 32'hFFFFEEEE, ALIGN, ALIGN ? 1 : 7, ALIGN ? 0 : 1});
    vt.push_back('{0, 2'b01, 0, 17, 0, 32'hFFFFFFEE, 0, 7, 1});

    // Reset state
    #1;
    check_reset_outputs("rst0");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vt[i]) begin
      model(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, e_rd, e_err, e_lat, e_en);
      run_access($sformatf("vec%0d", i), vt[i].we, vt[i].size, vt[i].uns, vt[i].addr,
                 vt[i].wdata, vt[i].rdata, vt[i].err, vt[i].lat, vt[i].en);
    end

    // Random traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      bit                r_we, r_uns;
      logic [1:0]        r_sz;
      logic [ADDR_W-1:0] r_ad;
      logic [31:0]       r_wd;
      r_we = 1'($urandom);
      r_uns = 1'($urandom);
      r_sz = 2'($urandom);
      r_ad = ADDR_W'($urandom_range(0, 60));
      r_wd = $urandom;
      model(r_we, r_sz, r_uns, r_ad, r_wd, e_rd, e_err, e_lat, e_en);
      run_access($sformatf("rnd%0d", i), r_we, r_sz, r_uns, r_ad, r_wd, e_rd, e_err, e_lat, e_en);
    end

    // Timeout, then a late op_r must not produce a response
    ctl_en = 1'b0;
    run_access("timeout", 1'b0, 2'b00, 1'b0, '0, '0, 32'h0, 1'b1, TO + 2, 1);
    repeat (2) @(negedge clk);
    inj_op_r = 1'b1;
    @(negedge clk);
    inj_op_r = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    check("late_op_r.resp", 32'(cnt), 32'd0);
    check("late_op_r.ready", 32'(req_ready), 32'd1);
    ctl_en = 1'b1;

    // req_valid held high: next accept only after RESP
    req_valid = 1'b1; req_size = 2'b11; req_we = 1'b0;
    pat = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      pat[c-1] = resp_valid;
    end
    req_valid = 1'b0;
    check("held_valid.pattern", 32'(pat), 32'h5);
    @(negedge clk);

    // Reset during WAIT with a controller completion still in flight
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 16;
    @(negedge clk);
    req_valid = 1'b0;
    check("midrst.issue", 32'(mem_enable), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid || mem_enable) cnt++;
    end
    check("midrst.quiet", 32'(cnt), 32'd0);
    check_reset_outputs("midrst_after");

    // Recovery after reset
    model(1'b0, 2'b00, 1'b0, 16, 0, e_rd, e_err, e_lat, e_en);
    run_access("recover", 1'b0, 2'b00, 1'b0, 16, 0, e_rd, e_err, e_lat, e_en);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
